data_bus_responder: RTL and testbench

Byte-wide responder on the CPU data bus: answers `mem_cs`/`mem_we`/`mem_oe` accesses issued by the control unit's bus interface. It provides the 128-byte data SRAM window (0x0040–0x00BF, shared with the stack) and a small diagnostics register bank at 0x0030–0x0034. The bank holds access counters, a stack low-water mark and sticky error flags. It sits beside the control unit in the top-level and is the only driver of `bus_data` during reads.

---
 rtl/data_bus_responder_pkg.sv | 29 ++
 rtl/data_bus_responder_sram.sv | 26 ++
 rtl/data_bus_responder.sv | 173 +++++++++++++++++
 tb/tb_data_bus_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_responder_pkg.sv
// Shared constants for the data bus responder: IO register map, STATUS/CTRL
// bit positions, access FSM states and the LOW_WATER "nothing written" value.
package data_bus_responder_pkg;

  localparam int IO_NUM_REGS = 5;

  localparam logic [2:0] IO_STATUS    = 3'd0;
  localparam logic [2:0] IO_CTRL      = 3'd1;
  localparam logic [2:0] IO_RD_CNT    = 3'd2;
  localparam logic [2:0] IO_WR_CNT    = 3'd3;
  localparam logic [2:0] IO_LOW_WATER = 3'd4;

  localparam int STATUS_W         = 2;
  localparam int STATUS_RANGE_ERR = 0;
  localparam int STATUS_RW_ERR    = 1;

  localparam int CTRL_CLR_ERR = 0;
  localparam int CTRL_CLR_CNT = 1;

  localparam logic [7:0] LOW_WATER_NONE = 8'hFF;

  typedef enum logic [1:0] {
    RESP_IDLE  = 2'd0,
    RESP_READ  = 2'd1,
    RESP_WRITE = 2'd2,
    RESP_ERR   = 2'd3
  } resp_state_e;

endpackage

// File: rtl/data_bus_responder_sram.sv
// Data SRAM backing store: asynchronous read, synchronous write, no reset.
module data_sram_array #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 8,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Commit one byte per write enable; contents survive reset untouched.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/data_bus_responder.sv
// Byte-wide data bus responder: SRAM window plus a diagnostics register bank
// (STATUS, CTRL, RD_CNT, WR_CNT, LOW_WATER). Sole driver of bus_data on reads.
//
// state      | meaning
// RESP_IDLE  | no access in progress; side effects fire on leaving this state
// RESP_READ  | read access held (cs & oe only)
// RESP_WRITE | write access held (cs & we only)
// RESP_ERR   | both strobes seen at access start, held until cs drops
module data_bus_responder
  import data_bus_responder_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ADDR_WIDTH     = 16,
  parameter logic [ADDR_WIDTH-1:0] MEM_START_ADDR = 16'h0040,
  parameter logic [ADDR_WIDTH-1:0] MEM_STOP_ADDR  = 16'h00BF,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE_ADDR   = 16'h0030
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  inout  wire  [DATA_WIDTH-1:0] bus_data,
  input  logic                  mem_cs,
  input  logic                  mem_we,
  input  logic                  mem_oe,
  output logic                  err
);

  localparam int MEM_DEPTH = int'(MEM_STOP_ADDR) - int'(MEM_START_ADDR) + 1;
  localparam int MEM_AW    = $clog2(MEM_DEPTH);

  function automatic logic [DATA_WIDTH-1:0] sat_inc(input logic [DATA_WIDTH-1:0] v);
    return (&v) ? v : v + DATA_WIDTH'(1);
  endfunction

  resp_state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [DATA_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [DATA_WIDTH-1:0] low_water_q, low_water_d;
  logic [STATUS_W-1:0]   status_q, status_d;
  logic                  err_q, err_d;

  logic [ADDR_WIDTH-1:0] mem_off_full, io_off_full;
  logic [MEM_AW-1:0]     mem_off;
  logic [2:0]            io_off;
  logic                  sram_hit, io_hit;
  logic                  rd_strobe, wr_strobe, rw_strobe, entry;
  logic                  rd_drive, sram_we;
  logic [DATA_WIDTH-1:0] sram_rdata, rd_data;
  logic                  unused_addr_bits;

  assign mem_off_full = bus_addr - MEM_START_ADDR;
  assign io_off_full  = bus_addr - IO_BASE_ADDR;
  assign mem_off      = mem_off_full[MEM_AW-1:0];
  assign io_off       = io_off_full[2:0];
  assign unused_addr_bits = ^{mem_off_full[ADDR_WIDTH-1:MEM_AW], io_off_full[ADDR_WIDTH-1:3]};

  assign sram_hit = (bus_addr >= MEM_START_ADDR) && (bus_addr <= MEM_STOP_ADDR);
  assign io_hit   = (bus_addr >= IO_BASE_ADDR) && (io_off_full < ADDR_WIDTH'(IO_NUM_REGS));

  assign rd_strobe = mem_oe & ~mem_we;
  assign wr_strobe = mem_we & ~mem_oe;
  assign rw_strobe = mem_we & mem_oe;
  assign entry     = (state_q == RESP_IDLE) & mem_cs & (mem_we | mem_oe);

  // Gated by reset so a write pending when reset drops cannot land in the array.
  assign sram_we  = reset & entry & wr_strobe & sram_hit;
  assign rd_drive = reset & mem_cs & rd_strobe & (sram_hit | io_hit);

  data_sram_array #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (DATA_WIDTH),
    .AW    (MEM_AW)
  ) u_sram (
    .clk   (clk),
    .we    (sram_we),
    .waddr (mem_off),
    .wdata (bus_data),
    .raddr (mem_off),
    .rdata (sram_rdata)
  );

  // Read value mux: SRAM byte or diagnostics register; CTRL reads as zero.
  always_comb begin
    rd_data = '0;
    if (sram_hit) begin
      rd_data = sram_rdata;
    end else if (io_hit) begin
      case (io_off)
        IO_STATUS:    rd_data = DATA_WIDTH'(status_q);
        IO_RD_CNT:    rd_data = rd_cnt_q;
        IO_WR_CNT:    rd_data = wr_cnt_q;
        IO_LOW_WATER: rd_data = low_water_q;
        default:      rd_data = '0;
      endcase
    end
  end

  assign bus_data = rd_drive ? rd_data : 'z;

  // Access FSM next state: classify on cs rising, hold until cs drops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RESP_IDLE: begin
        if (mem_cs) begin
          if (rd_strobe)      state_d = RESP_READ;
          else if (wr_strobe) state_d = RESP_WRITE;
          else if (rw_strobe) state_d = RESP_ERR;
        end
      end
      default: begin
        if (!mem_cs) state_d = RESP_IDLE;
      end
    endcase
  end

  // Diagnostics bank updates, applied only on the first cycle of an access.
  always_comb begin
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    low_water_d = low_water_q;
    status_d    = status_q;
    if (entry) begin
      if (rw_strobe) begin
        status_d[STATUS_RW_ERR] = 1'b1;
      end else if (!sram_hit && !io_hit) begin
        status_d[STATUS_RANGE_ERR] = 1'b1;
      end else if (sram_hit) begin
        if (rd_strobe) begin
          rd_cnt_d = sat_inc(rd_cnt_q);
        end else begin
          wr_cnt_d = sat_inc(wr_cnt_q);
          if (DATA_WIDTH'(mem_off) < low_water_q) begin
            low_water_d = DATA_WIDTH'(mem_off);
          end
        end
      end else if (wr_strobe && (io_off == IO_CTRL)) begin
        // Clears take priority over any concurrent bank update.
        if (bus_data[CTRL_CLR_ERR]) begin
          status_d = '0;
        end
        if (bus_data[CTRL_CLR_CNT]) begin
          rd_cnt_d    = '0;
          wr_cnt_d    = '0;
          low_water_d = DATA_WIDTH'(LOW_WATER_NONE);
        end
      end
    end
    err_d = |status_d;
  end

  // State, bank and err flops with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RESP_IDLE;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      low_water_q <= DATA_WIDTH'(LOW_WATER_NONE);
      status_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      low_water_q <= low_water_d;
      status_q    <= status_d;
      err_q       <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Testbench for data_bus_responder: directed vector table, hand-written
// multi-cycle sequences, then random accesses against a behavioural model.
module tb_data_bus_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] bus_addr = '0;
  logic        mem_cs = 1'b0, mem_we = 1'b0, mem_oe = 1'b0;
  logic        err;
  logic [7:0]  tb_drv = '0;
  logic        tb_en = 1'b0;
  wire  [7:0]  bus_data;

  assign bus_data = tb_en ? tb_drv : 8'hzz;
  pullup (bus_data);

  data_bus_responder dut (
    .clk      (clk),
    .reset    (reset),
    .bus_addr (bus_addr),
    .bus_data (bus_data),
    .mem_cs   (mem_cs),
    .mem_we   (mem_we),
    .mem_oe   (mem_oe),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural model of the responder's architectural state.
  logic [7:0] m_mem [128];
  bit         m_known [128];
  int         m_rd, m_wr, m_lw;
  bit         m_rng, m_rw;

  task automatic model_reset();
    m_rd = 0; m_wr = 0; m_lw = 255; m_rng = 0; m_rw = 0;
  endtask

  task automatic model_acc(input logic [15:0] a, input logic we, input logic oe, input logic [7:0] wd,
                           output bit drv, output logic [7:0] rv, output bit known);
    int off;
    drv = 0; rv = 8'hFF; known = 1;
    if (!we && !oe) return;
    if (we && oe) begin m_rw = 1; return; end
    if (a >= 16'h0040 && a <= 16'h00BF) begin
      off = int'(a) - 'h40;
      if (oe) begin
        drv = 1; rv = m_mem[off]; known = m_known[off];
        if (m_rd < 255) m_rd++;
      end else begin
        m_mem[off] = wd; m_known[off] = 1;
        if (m_wr < 255) m_wr++;
        if (off < m_lw) m_lw = off;
      end
    end else if (a >= 16'h0030 && a <= 16'h0034) begin
      off = int'(a) - 'h30;
      if (oe) begin
        drv = 1;
        case (off)
          0: rv = {6'b0, m_rw, m_rng};
          2: rv = 8'(m_rd);
          3: rv = 8'(m_wr);
          4: rv = 8'(m_lw);
          default: rv = 8'h00;
        endcase
      end else if (off == 1) begin
        if (wd[0]) begin m_rng = 0; m_rw = 0; end
        if (wd[1]) begin m_rd = 0; m_wr = 0; m_lw = 255; end
      end
    end else begin
      m_rng = 1;
    end
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One bus access: strobes held for `hold` cycles, then one cycle of cs low.
  task automatic do_acc(input logic [15:0] a, input logic we, input logic oe, input logic [7:0] wd,
                        input int hold, output logic [7:0] rv,
                        output bit e_drv, output logic [7:0] e_val, output bit e_known);
    @(negedge clk);
    bus_addr = a; mem_we = we; mem_oe = oe; tb_drv = wd; tb_en = we & ~oe; mem_cs = 1'b1;
    #1 rv = bus_data;
    model_acc(a, we, oe, wd, e_drv, e_val, e_known);
    repeat (hold - 1) @(negedge clk);
    @(negedge clk);
    mem_cs = 1'b0; mem_we = 1'b0; mem_oe = 1'b0; tb_en = 1'b0;
    #1;
  endtask

  logic [7:0] rv, e_val;
  bit         e_drv, e_known;

  task automatic rd_chk(input string nm, input logic [15:0] a, input logic [7:0] exp);
    do_acc(a, 1'b0, 1'b1, 8'h00, 1, rv, e_drv, e_val, e_known);
    check(nm, {8'h00, rv}, {8'h00, exp});
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    do_acc(a, 1'b1, 1'b0, d, 1, rv, e_drv, e_val, e_known);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic        oe;
    logic [7:0]  wdata;
    bit          chk;
    logic [7:0]  exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [15:0] a, input logic we, input logic oe, input logic [7:0] wd,
                              input bit chk, input logic [7:0] ed, input logic ee);
    vec_t v;
    v.addr = a; v.we = we; v.oe = oe; v.wdata = wd; v.chk = chk; v.exp_data = ed; v.exp_err = ee;
    vecs.push_back(v);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) m_known[i] = 0;
    model_reset();

    // Directed vectors: {addr, we, oe, wdata, check bus?, expected bus, expected err}
    add(16'h0040, 1, 0, 8'hA5, 0, 8'h00, 0);
    add(16'h0040, 0, 1, 8'h00, 1, 8'hA5, 0);
    add(16'h0033, 0, 1, 8'h00, 1, 8'h01, 0);
    add(16'h0032, 0, 1, 8'h00, 1, 8'h01, 0);
    add(16'h0034, 0, 1, 8'h00, 1, 8'h00, 0);
    add(16'h0031, 1, 0, 8'h02, 0, 8'h00, 0);
    add(16'h00BF, 1, 0, 8'h11, 0, 8'h00, 0);
    add(16'h00BE, 1, 0, 8'h22, 0, 8'h00, 0);
    add(16'h00BD, 1, 0, 8'h33, 0, 8'h00, 0);
    add(16'h0034, 0, 1, 8'h00, 1, 8'h7D, 0);
    add(16'h0050, 1, 0, 8'h44, 0, 8'h00, 0);
    add(16'h0034, 0, 1, 8'h00, 1, 8'h10, 0);
    add(16'h00BE, 0, 1, 8'h00, 1, 8'h22, 0);
    add(16'h0100, 0, 1, 8'h00, 1, 8'hFF, 1);
    add(16'h0030, 0, 1, 8'h00, 1, 8'h01, 1);
    add(16'h0031, 1, 0, 8'h01, 0, 8'h00, 0);
    add(16'h0030, 0, 1, 8'h00, 1, 8'h00, 0);
    add(16'h0032, 1, 0, 8'h77, 0, 8'h00, 0);
    add(16'h0032, 0, 1, 8'h00, 1, 8'h01, 0);
    add(16'h0033, 0, 1, 8'h00, 1, 8'h04, 0);
    add(16'h0035, 1, 0, 8'h99, 0, 8'h00, 1);
    add(16'h0030, 0, 1, 8'h00, 1, 8'h01, 1);
    add(16'h002F, 0, 1, 8'h00, 1, 8'hFF, 1);
    add(16'h00C0, 0, 1, 8'h00, 1, 8'hFF, 1);
    add(16'h0031, 0, 1, 8'h00, 1, 8'h00, 1);
    add(16'h0031, 1, 0, 8'h03, 0, 8'h00, 0);
    add(16'h0032, 0, 1, 8'h00, 1, 8'h00, 0);
    add(16'h0033, 0, 1, 8'h00, 1, 8'h00, 0);
    add(16'h0034, 0, 1, 8'h00, 1, 8'hFF, 0);
    add(16'h0040, 0, 1, 8'h00, 1, 8'hA5, 0);

    repeat (3) @(negedge clk);
    check("reset_err", {15'd0, err}, 16'h0000);
    check("reset_bus", {8'h00, bus_data}, 16'h00FF);
    reset = 1'b1;

    foreach (vecs[i]) begin
      do_acc(vecs[i].addr, vecs[i].we, vecs[i].oe, vecs[i].wdata, 1, rv, e_drv, e_val, e_known);
      if (vecs[i].chk) check($sformatf("vec%0d_bus", i), {8'h00, rv}, {8'h00, vecs[i].exp_data});
      check($sformatf("vec%0d_err", i), {15'd0, err}, {15'd0, vecs[i].exp_err});
    end

    // Held write and held read count once each.
    do_acc(16'h0060, 1'b1, 1'b0, 8'h00, 3, rv, e_drv, e_val, e_known);
    rd_chk("hold_wr_cnt", 16'h0033, 8'h01);
    do_acc(16'h0060, 1'b0, 1'b1, 8'h00, 3, rv, e_drv, e_val, e_known);
    check("hold_rd_data", {8'h00, rv}, 16'h0000);
    rd_chk("hold_rd_cnt", 16'h0032, 8'h02);

    // Both strobes: no drive, no write, RW_ERR.
    do_acc(16'h0060, 1'b1, 1'b1, 8'h5A, 1, rv, e_drv, e_val, e_known);
    check("both_nodrive", {8'h00, rv}, 16'h00FF);
    check("both_err", {15'd0, err}, 16'h0001);
    rd_chk("both_status", 16'h0030, 8'h02);
    rd_chk("both_nowrite", 16'h0060, 8'h00);

    // cs with no strobe leaves everything alone.
    do_acc(16'h0040, 1'b0, 1'b0, 8'h00, 2, rv, e_drv, e_val, e_known);
    check("nostrobe_bus", {8'h00, rv}, 16'h00FF);

    // Read counter saturation, then counter clear.
    wr(16'h0031, 8'h03);
    for (int i = 0; i < 260; i++) begin
      do_acc(16'h0040, 1'b0, 1'b1, 8'h00, 1, rv, e_drv, e_val, e_known);
      if (rv !== 8'hA5) check("sat_rd_data", {8'h00, rv}, 16'h00A5);
    end
    rd_chk("sat_rd_cnt", 16'h0032, 8'hFF);
    wr(16'h0031, 8'h02);
    rd_chk("clr_rd_cnt", 16'h0032, 8'h00);
    rd_chk("clr_wr_cnt", 16'h0033, 8'h00);
    rd_chk("clr_low_water", 16'h0034, 8'hFF);

    // Reset asserted during a write before its edge.
    wr(16'h0070, 8'h12);
    rd_chk("pre_rst_miss", 16'h0200, 8'hFF);
    check("pre_rst_err", {15'd0, err}, 16'h0001);
    @(negedge clk);
    bus_addr = 16'h0070; mem_we = 1'b1; tb_drv = 8'h34; tb_en = 1'b1; mem_cs = 1'b1;
    #2 reset = 1'b0;
    #1 check("rst_err_async", {15'd0, err}, 16'h0000);
    @(negedge clk);
    mem_cs = 1'b0; mem_we = 1'b0; tb_en = 1'b0;
    #1 check("rst_bus", {8'h00, bus_data}, 16'h00FF);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    rd_chk("rst_rd_cnt", 16'h0032, 8'h00);
    rd_chk("rst_wr_cnt", 16'h0033, 8'h00);
    rd_chk("rst_low_water", 16'h0034, 8'hFF);
    rd_chk("rst_status", 16'h0030, 8'h00);
    rd_chk("rst_keep_old", 16'h0070, 8'h12);

    // Random accesses against the model.
    for (int i = 0; i < 300; i++) begin
      logic [15:0] a;
      logic        we, oe;
      int          r, s;
      r = int'($urandom_range(0, 9));
      if (r < 3)      a = 16'h0040 + 16'($urandom_range(0, 15));
      else if (r < 6) a = 16'($urandom_range(16'h0040, 16'h00BF));
      else if (r < 9) a = 16'h0030 + 16'($urandom_range(0, 4));
      else if (r == 9 && $urandom_range(0, 1) == 0) a = 16'($urandom_range(16'h0035, 16'h003F));
      else a = 16'($urandom_range(16'h00C0, 16'hFFFF));
      s = int'($urandom_range(0, 7));
      we = (s >= 3 && s <= 6);
      oe = (s <= 2 || s == 6);
      do_acc(a, we, oe, 8'($urandom), int'($urandom_range(1, 3)), rv, e_drv, e_val, e_known);
      if (!(we && !oe)) begin
        if (e_drv) begin
          if (e_known) check($sformatf("rand%0d_rd@%h", i, a), {8'h00, rv}, {8'h00, e_val});
        end else begin
          check($sformatf("rand%0d_nodrive@%h", i, a), {8'h00, rv}, 16'h00FF);
        end
      end
      check($sformatf("rand%0d_err", i), {15'd0, err}, {15'd0, (m_rng | m_rw)});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
